// File: rtl/tile_ram_arbiter_pkg.sv
// Shared types and constants for the tile RAM arbiter: FSM states, requester IDs,
// renderer lead time.
package tile_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // Cycles between vid_busy rising and the renderer's first RAM read.
  localparam int VID_BUSY_LEAD = 5;

  function automatic req_id_t other_side(input req_id_t id);
    return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
  endfunction

endpackage

// File: rtl/ram_write_buffer.sv
// One-entry posted-write holding register (address, data, full flag).
// Compiled in only when TILE_RAM_WRITE_POST_EN is defined.
`ifdef TILE_RAM_WRITE_POST_EN
module ram_write_buffer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              drain,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: the renderer owns the RAM while vid_busy is high, CPU and DMA share
// the gaps round-robin. Define TILE_RAM_WRITE_POST_EN for a one-entry posted CPU write buffer.
module tile_ram_arbiter
  import tile_ram_arbiter_pkg::*;
#(
  parameter int ACC_CYCLES = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_busy,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [15:0]       dma_wdata,
  output logic              dma_ack,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata
);

  localparam int              CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

  state_t            state;
  req_id_t           rr, grant, pick;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic              lat_we, lat_post, cpu_done_ack;

  logic              cpu_arb_req, cpu_arb_we, cpu_arb_post;
  logic [ADDR_W-1:0] cpu_arb_addr;
  logic [15:0]       cpu_arb_wdata;

`ifdef TILE_RAM_WRITE_POST_EN
  logic              wb_full, wb_load, wb_drain, post_ack;
  logic [ADDR_W-1:0] wb_addr;
  logic [15:0]       wb_data;

  assign wb_load  = cpu_req && cpu_we && !wb_full && !post_ack;
  assign wb_drain = (state == ST_DONE) && lat_post;

  ram_write_buffer #(.ADDR_W(ADDR_W)) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .load      (wb_load),
    .load_addr (cpu_addr),
    .load_data (cpu_wdata),
    .drain     (wb_drain),
    .full      (wb_full),
    .addr      (wb_addr),
    .data      (wb_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) post_ack <= 1'b0;
    else       post_ack <= wb_load;
  end

  // A held write drains ahead of any CPU read so the CPU always sees its own data.
  assign cpu_arb_req   = wb_full || (cpu_req && !cpu_we);
  assign cpu_arb_we    = wb_full;
  assign cpu_arb_addr  = wb_full ? wb_addr : cpu_addr;
  assign cpu_arb_wdata = wb_data;
  assign cpu_arb_post  = wb_full;
  assign cpu_ack       = cpu_done_ack || post_ack;
`else
  assign cpu_arb_req   = cpu_req;
  assign cpu_arb_we    = cpu_we;
  assign cpu_arb_addr  = cpu_addr;
  assign cpu_arb_wdata = cpu_wdata;
  assign cpu_arb_post  = 1'b0;
  assign cpu_ack       = cpu_done_ack;
`endif

  always_comb begin
    if (cpu_arb_req && dma_req) pick = rr;
    else if (cpu_arb_req)       pick = REQ_CPU;
    else                        pick = REQ_DMA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      rr           <= REQ_CPU;
      grant        <= REQ_CPU;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_we       <= 1'b0;
      lat_post     <= 1'b0;
      ram_we       <= 1'b0;
      cpu_done_ack <= 1'b0;
      dma_ack      <= 1'b0;
      rdata        <= '0;
    end else begin
      ram_we       <= 1'b0;
      cpu_done_ack <= 1'b0;
      dma_ack      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!vid_busy && (cpu_arb_req || dma_req)) begin
            grant     <= pick;
            rr        <= other_side(pick);
            lat_addr  <= (pick == REQ_CPU) ? cpu_arb_addr  : dma_addr;
            lat_wdata <= (pick == REQ_CPU) ? cpu_arb_wdata : dma_wdata;
            lat_we    <= (pick == REQ_CPU) ? cpu_arb_we    : dma_we;
            ram_we    <= (pick == REQ_CPU) ? cpu_arb_we    : dma_we;
            lat_post  <= (pick == REQ_CPU) && cpu_arb_post;
            cnt       <= CNT_LOAD;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            if (!lat_we) rdata <= ram_rdata;
            // Drained posted writes were already acknowledged when buffered.
            if (grant == REQ_CPU) cpu_done_ack <= !lat_post;
            else                  dma_ack      <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr  = (state == ST_IDLE) ? vid_addr : lat_addr;
  assign ram_wdata = lat_wdata;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Self-checking bench for tile_ram_arbiter: vector table, directed corner sequences,
// then randomized CPU/DMA/renderer traffic against a transaction-level memory model.
module tb_tile_ram_arbiter;

  localparam int ACC = 2;
  localparam int AW  = 16;
`ifdef TILE_RAM_WRITE_POST_EN
  localparam int CPU_WR_LAT = 1;
`else
  localparam int CPU_WR_LAT = ACC + 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_busy;
  logic [AW-1:0] vid_addr;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_wdata;
  logic [15:0]   rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          ram_we;
  logic [15:0]   ram_rdata;

  logic [15:0]   mem [0:65535];

  int checks = 0;
  int errors = 0;

  tile_ram_arbiter #(.ACC_CYCLES(ACC), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .vid_busy  (vid_busy),
    .vid_addr  (vid_addr),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read-before-write, one cycle read latency.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input bit dma, input int budget, output int lat, output bit other);
    lat   = -1;
    other = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (dma ? cpu_ack : dma_ack) other = 1'b1;
      if (dma ? dma_ack : cpu_ack) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic contend(input bit c, input bit d, output int first, output int t_c, output int t_d);
    int n;
    cpu_we  = 1'b0;
    dma_we  = 1'b0;
    cpu_req = c;
    dma_req = d;
    first = -1; t_c = -1; t_d = -1; n = 0;
    while ((cpu_req || dma_req) && n < 40) begin
      tick();
      n++;
      if (cpu_ack && cpu_req) begin
        t_c = n; cpu_req = 1'b0;
        if (first < 0) first = 0;
      end
      if (dma_ack && dma_req) begin
        t_d = n; dma_req = 1'b0;
        if (first < 0) first = 1;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          dma;
    bit          we;
    bit          pre;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pre_val;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  // Random-phase state, one slot per master (0 = CPU, 1 = DMA).
  bit          act[2];
  bit          we_q[2];
  logic [15:0] addr_q[2];
  logic [15:0] data_q[2];
  int          start[2];
  int          gap[2];
  int          last_ack[2];
  logic [15:0] shadow[16];

  initial begin
    int  lat, first, t_c, t_d, cyc, busy_run, vb, vidle, o;
    bit  oth, seen, ok, a, viol;

    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0123, 16'h0000, 16'hBEEF, 16'hBEEF, ACC + 1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1357, 16'h1357, ACC + 1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 16'h0000, 16'hA5A5, CPU_WR_LAT};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0F0F, 16'h1111, 16'h0F0F, ACC + 1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, ACC + 1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h7E7E, 16'h7E7E, ACC + 1};

    reset = 1'b1; vid_busy = 1'b0; vid_addr = 16'h1234;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    tick();
    chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("rst_dma_ack", 32'(dma_ack), 32'(0));
    chk("rst_ram_we", 32'(ram_we), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_ram_addr", 32'(ram_addr), 32'h1234);
    reset = 1'b0;
    tick();

    // Single uncontended transactions.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre) mem[vecs[i].addr] = vecs[i].pre_val;
      if (vecs[i].dma) begin
        dma_we = vecs[i].we; dma_addr = vecs[i].addr; dma_wdata = vecs[i].wdata; dma_req = 1'b1;
      end else begin
        cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata; cpu_req = 1'b1;
      end
      wait_ack(vecs[i].dma, 20, lat, oth);
      cpu_req = 1'b0; dma_req = 1'b0;
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_other_ack", i), 32'(oth), 32'(0));
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp));
      repeat (4) tick();
      if (vecs[i].we) chk($sformatf("vec%0d_mem", i), 32'(mem[vecs[i].addr]), 32'(vecs[i].exp));
    end

    // Round robin: pointer starts at CPU, flips to the side opposite each grant.
    cpu_addr = 16'h0123; dma_addr = 16'hFFFF;
    contend(1'b1, 1'b1, first, t_c, t_d);
    chk("rr1_first", 32'(first), 32'(0));
    chk("rr1_cpu_lat", 32'(t_c), 32'(ACC + 1));
    chk("rr1_dma_lat", 32'(t_d), 32'(2 * ACC + 3));
    contend(1'b1, 1'b1, first, t_c, t_d);
    chk("rr2_first", 32'(first), 32'(0));
    contend(1'b1, 1'b0, first, t_c, t_d);
    chk("rr3_cpu_alone", 32'(t_c), 32'(ACC + 1));
    contend(1'b1, 1'b1, first, t_c, t_d);
    chk("rr4_first", 32'(first), 32'(1));
    chk("rr4_dma_lat", 32'(t_d), 32'(ACC + 1));
    chk("rr4_cpu_lat", 32'(t_c), 32'(2 * ACC + 3));

    // Renderer holds the RAM while a CPU read waits.
    cpu_we = 1'b0; cpu_addr = 16'h0123; vid_busy = 1'b1; vid_addr = 16'h3000; cpu_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= cpu_ack;
      chk("busy_tracks_vid", 32'(ram_addr), 32'(vid_addr));
      vid_addr = vid_addr + 16'h0101;
    end
    chk("busy_no_ack", 32'(seen), 32'(0));
    vid_busy = 1'b0;
    wait_ack(1'b0, 20, lat, oth);
    cpu_req = 1'b0;
    chk("busy_release_lat", 32'(lat), 32'(ACC + 1));
    chk("busy_release_rdata", 32'(rdata), 32'hBEEF);
    repeat (2) tick();

    // vid_busy rises one cycle into ACCESS: the access still completes.
    mem[16'h0200] = 16'h1111;
    cpu_addr = 16'h0200; cpu_req = 1'b1;
    tick();
    vid_busy = 1'b1; vid_addr = 16'h7777;
    chk("late_busy_latched_addr", 32'(ram_addr), 32'h0200);
    tick();
    chk("late_busy_no_early_ack", 32'(cpu_ack), 32'(0));
    tick();
    chk("late_busy_ack", 32'(cpu_ack), 32'(1));
    chk("late_busy_rdata", 32'(rdata), 32'h1111);
    cpu_req = 1'b0;
    tick();
    chk("late_busy_vid_addr", 32'(ram_addr), 32'h7777);
    repeat (3) tick();
    vid_busy = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a write.
    mem[16'h0300] = 16'h0BAD;
    cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'hDEAD; cpu_req = 1'b1;
    tick();
    chk("midrst_we_before", 32'(ram_we), 32'(1));
    reset = 1'b1;
    #1;
    chk("midrst_we_drop", 32'(ram_we), 32'(0));
    chk("midrst_acks", 32'({cpu_ack, dma_ack}), 32'(0));
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= cpu_ack | dma_ack;
    end
    chk("midrst_no_stale_ack", 32'(seen), 32'(0));
    chk("midrst_mem_untouched", 32'(mem[16'h0300]), 32'h0BAD);

`ifdef TILE_RAM_WRITE_POST_EN
    // Posted write under vid_busy, then an ordered read of the same word.
    vid_busy = 1'b1; vid_addr = 16'h2222;
    cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h55AA; cpu_req = 1'b1;
    wait_ack(1'b0, 5, lat, oth);
    cpu_req = 1'b0;
    chk("post_wr_lat", 32'(lat), 32'(1));
    tick();
    cpu_we = 1'b0; cpu_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= cpu_ack;
    end
    chk("post_rd_waits", 32'(seen), 32'(0));
    vid_busy = 1'b0;
    wait_ack(1'b0, 30, lat, oth);
    cpu_req = 1'b0;
    chk("post_rd_done", 32'(lat > 0), 32'(1));
    chk("post_rd_data", 32'(rdata), 32'h55AA);
    repeat (3) tick();
`else
    // Randomized traffic checked against an in-order memory model and fairness rules.
    for (int i = 0; i < 16; i++) shadow[i] = mem[16'h0400 + 16'(i)];
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; gap[m] = m; last_ack[m] = -100; start[m] = 0;
      we_q[m] = 1'b0; addr_q[m] = 16'h0400; data_q[m] = '0;
    end
    cyc = 0; busy_run = 0; vb = 0; vidle = 8; vid_busy = 1'b0;
    repeat (3000) begin
      tick();
      cyc++;
      busy_run = vid_busy ? busy_run + 1 : 0;
      // Worst case a grant taken just before busy rises still needs ACC+1 cycles to return.
      if (busy_run >= ACC + 1) begin
        chk("rand_vid_owns_addr", 32'(ram_addr), 32'(vid_addr));
        chk("rand_vid_no_we", 32'(ram_we), 32'(0));
      end
      if (ram_we) begin
        ok = 1'b0;
        for (int m = 0; m < 2; m++)
          if (act[m] && we_q[m] && addr_q[m] == ram_addr && data_q[m] == ram_wdata) ok = 1'b1;
        chk("rand_we_matches_pending", 32'(ok), 32'(1));
      end
      chk("rand_single_ack", 32'(cpu_ack && dma_ack), 32'(0));
      for (int m = 0; m < 2; m++) begin
        a = (m == 1) ? dma_ack : cpu_ack;
        o = 1 - m;
        if (a) begin
          chk("rand_ack_has_req", 32'(act[m]), 32'(1));
          if (act[m]) begin
            viol = (last_ack[m] > last_ack[o]) && act[o] && (start[o] <= last_ack[m] + 1);
            chk("rand_rr_fair", 32'(viol), 32'(0));
            if (we_q[m]) shadow[addr_q[m][3:0]] = data_q[m];
            else         chk("rand_rdata", 32'(rdata), 32'(shadow[addr_q[m][3:0]]));
            last_ack[m] = cyc;
            act[m] = 1'b0;
            gap[m] = int'($urandom_range(0, 3));
          end
        end else if (act[m] && cyc - start[m] > 200) begin
          chk("rand_ack_timeout", 32'(1), 32'(0));
          act[m] = 1'b0;
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (!act[m]) begin
          if (gap[m] == 0) begin
            act[m]    = 1'b1;
            we_q[m]   = 1'($urandom_range(0, 1));
            addr_q[m] = 16'h0400 | 16'($urandom_range(0, 15));
            data_q[m] = 16'($urandom);
            start[m]  = cyc;
          end else begin
            gap[m]--;
          end
        end
      end
      cpu_req = act[0]; cpu_we = we_q[0]; cpu_addr = addr_q[0]; cpu_wdata = data_q[0];
      dma_req = act[1]; dma_we = we_q[1]; dma_addr = addr_q[1]; dma_wdata = data_q[1];
      if (vid_busy) begin
        if (vb == 0) begin
          vid_busy = 1'b0;
          vidle = int'($urandom_range(6, 25));
        end else vb--;
      end else begin
        if (vidle == 0) begin
          vid_busy = 1'b1;
          vb = int'($urandom_range(0, 14));
        end else vidle--;
      end
      vid_addr = 16'($urandom);
    end
    cpu_req = 1'b0; dma_req = 1'b0; vid_busy = 1'b0;
    repeat (10) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
